// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared defaults, FSM encoding and zero-register index for reg_file_mp.
package reg_file_mp_pkg;
    localparam int RF_XLEN             = 32;
    localparam int REG_FILE_ADDR_WIDTH = 5;
    localparam int RF_ZERO_REG         = 0;
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one asynchronous read port with zero/clear masking.
// Same-cycle write bypass is compiled in with REG_FILE_BYPASS_EN.
module reg_file_rd_port import reg_file_mp_pkg::*; #(
    parameter int XLEN       = RF_XLEN,
    parameter int ADDR_WIDTH = REG_FILE_ADDR_WIDTH,
    parameter int NUM_WR     = 1
) (
    input  logic [ADDR_WIDTH-1:0]        i_rs,
    input  logic [XLEN-1:0]              i_mem,
    input  logic                         i_run,
`ifdef REG_FILE_BYPASS_EN
    input  logic [NUM_WR-1:0]            i_we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_rd,
    input  logic [NUM_WR*XLEN-1:0]       i_wd,
`endif
    output logic [XLEN-1:0]              o_data
);
    logic [XLEN-1:0] w_val;
`ifdef REG_FILE_BYPASS_EN
    // Later ports override earlier ones, matching write priority.
    always_comb begin
        w_val = i_mem;
        for (int j = 0; j < NUM_WR; j++)
            if (i_we[j] && i_rd[j*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(RF_ZERO_REG) &&
                i_rd[j*ADDR_WIDTH +: ADDR_WIDTH] == i_rs)
                w_val = i_wd[j*XLEN +: XLEN];
    end
`else
    assign w_val = i_mem;
`endif
    assign o_data = (!i_run || i_rs == ADDR_WIDTH'(RF_ZERO_REG)) ? '0 : w_val;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with post-reset clear sweep and ready flag.
// Optional same-cycle write-to-read bypass via REG_FILE_BYPASS_EN.
module reg_file_mp import reg_file_mp_pkg::*; #(
    parameter int XLEN       = RF_XLEN,
    parameter int ADDR_WIDTH = REG_FILE_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rs,
    output logic [NUM_RD*XLEN-1:0]       data,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] rd,
    input  logic [NUM_WR*XLEN-1:0]       wd,
    output logic                         ready
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [XLEN-1:0]       r_mem [DEPTH];
    rf_state_e             r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;

    always_comb begin
        w_next = r_state;
        if (r_state == RF_CLEAR && r_clr_ptr == ADDR_WIDTH'(DEPTH-1))
            w_next = RF_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RF_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_next;
            if (r_state == RF_CLEAR)
                r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
        end
    end

    // Storage has no reset; the sweep zeroes one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!rst && r_state == RF_CLEAR)
            r_mem[r_clr_ptr] <= '0;
        else if (!rst)
            for (int j = 0; j < NUM_WR; j++)
                if (we[j] && rd[j*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(RF_ZERO_REG))
                    r_mem[rd[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wd[j*XLEN +: XLEN];
    end

    assign ready = (r_state == RF_RUN);

    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : g_rd
            reg_file_rd_port #(
                .XLEN       (XLEN),
                .ADDR_WIDTH (ADDR_WIDTH),
                .NUM_WR     (NUM_WR)
            ) u_port (
                .i_rs   (rs[i*ADDR_WIDTH +: ADDR_WIDTH]),
                .i_mem  (r_mem[rs[i*ADDR_WIDTH +: ADDR_WIDTH]]),
                .i_run  (ready),
`ifdef REG_FILE_BYPASS_EN
                .i_we   (we),
                .i_rd   (rd),
                .i_wd   (wd),
`endif
                .o_data (data[i*XLEN +: XLEN])
            );
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp (NUM_RD=2, NUM_WR=2).
module tb_reg_file_mp;
    logic        clk = 0;
    logic        rst;
    logic [9:0]  rs;
    logic [63:0] data;
    logic [1:0]  we;
    logic [9:0]  rd;
    logic [63:0] wd;
    logic        ready;
    int          errors = 0;
    int          checks = 0;

    reg_file_mp #(.XLEN(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk(clk), .rst(rst), .rs(rs), .data(data),
        .we(we), .rd(rd), .wd(wd), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1; we = 2'b01; rd = {5'd0, 5'd5}; wd = {32'd0, 32'hAB}; rs = {5'd0, 5'd5};
        step(); step();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        rst = 0;
        step();
        checks++;
        if (data[31:0] !== 32'd0) begin errors++; $display("FAIL sweep_data got=%h exp=0", data[31:0]); end
        wait_ready(cyc);
        checks++;
        if (cyc + 1 !== 32) begin errors++; $display("FAIL sweep_len got=%0d exp=32", cyc + 1); end
        we = 2'b00;
        for (int r = 0; r < 32; r++) begin
            rs = {5'd0, 5'(r)};
            #1;
            checks++;
            if (data[31:0] !== 32'd0) begin errors++; $display("FAIL clear_r%0d got=%h exp=0", r, data[31:0]); end
        end
    endtask

    task automatic test_reg0();
        logic [31:0] vals [2] = '{32'hDEADBEEF, 32'h1};
        for (int k = 0; k < 2; k++) begin
            we = 2'b01; rd = {5'd0, 5'd0}; wd = {32'd0, vals[k]};
            step();
            we = 2'b00; rs = {5'd0, 5'd0};
            #1;
            checks++;
            if (data[31:0] !== 32'd0) begin errors++; $display("FAIL reg0_%0d got=%h exp=0", k, data[31:0]); end
        end
    endtask

    task automatic test_bypass_midsweep();
        int cyc;
        logic [31:0] exp_byp;
`ifdef REG_FILE_BYPASS_EN
        exp_byp = 32'hCAFE;
`else
        exp_byp = 32'h0;
`endif
        we = 2'b01; rd = {5'd0, 5'd12}; wd = {32'd0, 32'hCAFE}; rs = {5'd0, 5'd12};
        #1;
        checks++;
        if (data[31:0] !== exp_byp) begin errors++; $display("FAIL bypass got=%h exp=%h", data[31:0], exp_byp); end
        step();
        we = 2'b00;
        #1;
        checks++;
        if (data[31:0] !== 32'hCAFE) begin errors++; $display("FAIL after_write got=%h exp=cafe", data[31:0]); end
        we = 2'b01; rd = {5'd0, 5'd0}; wd = {32'd0, 32'h77}; rs = {5'd0, 5'd0};
        #1;
        checks++;
        if (data[31:0] !== 32'd0) begin errors++; $display("FAIL bypass_r0 got=%h exp=0", data[31:0]); end
        step();
        we = 2'b00;
        rst = 1; step(); rst = 0;
        for (int c = 0; c < 10; c++) step();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midsweep_ready got=%b exp=0", ready); end
        rst = 1; step(); rst = 0;
        wait_ready(cyc);
        checks++;
        if (cyc !== 32) begin errors++; $display("FAIL restart_len got=%0d exp=32", cyc); end
        rs = {5'd0, 5'd12};
        #1;
        checks++;
        if (data[31:0] !== 32'd0) begin errors++; $display("FAIL r12_cleared got=%h exp=0", data[31:0]); end
    endtask

    task automatic test_write_sweep();
        for (int n = 1; n < 32; n++) begin
            we = 2'b01; rd = {5'd0, 5'(n)}; wd = {32'd0, 32'(n)};
            step();
            we = 2'b00; rs = {5'(n + 1), 5'(n)};
            #1;
            checks++;
            if (data[31:0] !== 32'(n)) begin errors++; $display("FAIL wr_r%0d got=%h exp=%h", n, data[31:0], 32'(n)); end
            checks++;
            if (data[63:32] !== 32'd0) begin errors++; $display("FAIL next_r%0d got=%h exp=0", n + 1, data[63:32]); end
        end
    endtask

    task automatic test_we_gating();
        we = 2'b01; rd = {5'd0, 5'd7}; wd = {32'd0, 32'h55};
        step();
        we = 2'b00; wd = {32'h99, 32'h99}; rd = {5'd7, 5'd7};
        step(); step(); step();
        rs = {5'd0, 5'd7};
        #1;
        checks++;
        if (data[31:0] !== 32'h55) begin errors++; $display("FAIL we_gate got=%h exp=55", data[31:0]); end
    endtask

    task automatic test_dual_write();
        we = 2'b11; rd = {5'd9, 5'd9}; wd = {32'h22, 32'h11};
        step();
        we = 2'b00; rs = {5'd0, 5'd9};
        #1;
        checks++;
        if (data[31:0] !== 32'h22) begin errors++; $display("FAIL collision got=%h exp=22", data[31:0]); end
        we = 2'b11; rd = {5'd4, 5'd3}; wd = {32'h44, 32'h33};
        step();
        we = 2'b00; rs = {5'd4, 5'd3};
        #1;
        checks++;
        if (data[31:0] !== 32'h33) begin errors++; $display("FAIL dual_r3 got=%h exp=33", data[31:0]); end
        checks++;
        if (data[63:32] !== 32'h44) begin errors++; $display("FAIL dual_r4 got=%h exp=44", data[63:32]); end
    endtask

    initial begin
        test_reset();
        test_reg0();
        test_bypass_midsweep();
        test_write_sweep();
        test_we_gating();
        test_dual_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-write, dual-read integer register file.
- Configurable read-port count, one or two synchronous write ports, and a hardware clear sweep after reset, signalled by a ready flag.
- Register 0 is hardwired to zero.
- Sits in the decode stage of the 3-stage core. The second write port lets a future load/ALU dual-retire path share the file.

Parameters:
- XLEN, 32, data width in bits.
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 2, number of asynchronous read ports (1..4).
- NUM_WR, 1, number of synchronous write ports (1..2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs  in  NUM_RD*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- data  out  NUM_RD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- we  in  NUM_WR  per-port write enable, active high.
- rd  in  NUM_WR*ADDR_WIDTH  write addresses, packed as for rs.
- wd  in  NUM_WR*XLEN  write data, packed as for data.
- ready  out  1  high once the clear sweep has completed; writes are accepted only while high.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- FSM with two states, CLEAR and RUN.
- rst high at a posedge: state <= CLEAR, clr_ptr <= 0, ready <= 0. A reset mid-sweep restarts the sweep at 0.
- CLEAR state:
  - Each cycle writes 0 to entry clr_ptr, then clr_ptr <= clr_ptr + 1.
  - When clr_ptr == DEPTH-1, that entry is written and state <= RUN, ready <= 1.
  - The sweep takes exactly DEPTH cycles after rst deasserts.
  - All we inputs are ignored. All data outputs read 0.
- RUN state, writes:
  - At a posedge, each port j with we[j]=1 and rd_j != 0 writes wd_j to entry rd_j.
  - A write to entry 0 is discarded.
- Simultaneous writes (NUM_WR=2, rd_0 == rd_1, both enabled): port 1 wins.
- RUN state, reads:
  - data_i = (rs_i == 0) ? 0 : mem[rs_i].
  - Purely combinational; valid within one simulation timestep of an address change.
  - A value written at a posedge is visible on reads from the following cycle.
- Same-cycle read of an address being written: returns the old value, unless the optional bypass feature is compiled in.
- ready is registered and changes only at a posedge.
- After reset, memory contents are don't-care until the sweep passes them. Outputs are masked to 0 until ready=1.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - In RUN, a read whose rs_i matches an enabled write port's rd_j (rd_j != 0) returns wd_j combinationally in the same cycle.
  - Priority follows the write priority: port 1 over port 0.
  - This removes the writeback-to-decode hazard in the 3-stage pipeline.
- Undefined:
  - Reads return the stored value only.
  - The same-cycle read sees the pre-write value.

Decomposition:
- Shared package/header defines:
  - XLEN and REG_FILE_ADDR_WIDTH defaults.
  - FSM state encoding: RF_CLEAR=1'b0, RF_RUN=1'b1.
  - The zero-register index constant.
- One natural sub-module, reg_file_rd_port: a single read port containing the zero mask, the CLEAR mask and the optional bypass mux, instantiated NUM_RD times via generate.
- Storage, write logic and FSM stay in the top module.

Test Plan:
- Reset sweep:
  - Pulse rst for 2 cycles, then hold low.
  - ready stays 0 for exactly 32 cycles and rises at the 32nd posedge.
  - During the sweep, we=1, rd=5, wd=32'hAB has no effect.
  - Afterwards, every register reads 0.
- Register 0:
  - we=1, rd=0, wd=32'hDEADBEEF.
  - Next cycle, rs0=0 reads 0.
  - Repeat with wd=1: still reads 0.
- Write/read sweep:
  - For n=1..31, write wd=n to rd=n with we=1.
  - On the cycle after each write, rs0=n reads n.
  - rs1=n+1 reads 0 (not yet written).
- Write enable gating:
  - Write 32'h55 to r7, then drive we=0, rd=7, wd=32'h99 for 3 cycles.
  - r7 still reads 32'h55.
- Dual-write collision (NUM_WR=2):
  - Both ports write r9 in one cycle: port 0 with 32'h11, port 1 with 32'h22.
  - r9 reads 32'h22.
  - Separately, different addresses r3 and r4 written in one cycle both update.
- Bypass and mid-sweep reset:
  - Write r12=32'hCAFE while rs0=12 in the same cycle.
  - With REG_FILE_BYPASS_EN, data0=32'hCAFE in that cycle; without it, data0=0.
  - Then assert rst at clr_ptr=10: the sweep restarts and ready rises 32 cycles after rst drops.
